// File: rtl/ah_snoop_credit_fifo.sv
// rtl/ah_snoop_credit_fifo.sv - credit-flow-controlled FIFO of any depth with a masked content-snoop port
module ah_snoop_credit_fifo #(
    parameter int DATA_W    = 164,
    parameter int DEPTH     = 48,
    parameter int RCRED_MAX = 4,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wcredit,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rcredit,
    input  logic [DATA_W-1:0] sdata,
    input  logic [DATA_W-1:0] smask,
    input  logic              svalid,
    output logic              smatch,
    output logic [CNT_W-1:0]  smatch_cnt,
    output logic [CNT_W-1:0]  count,
    output logic              err_ovf,
    output logic              err_crd
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RC_W  = $clog2(RCRED_MAX + 1);
    localparam int OFF_W = CNT_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [RC_W-1:0]  RC_TOP   = RC_W'(RCRED_MAX);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [RC_W-1:0]   rc;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  hit;
    logic [CNT_W-1:0]  hit_cnt;
    logic [OFF_W-1:0]  off;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Full test uses the pre-pop occupancy, so a full FIFO rejects a write even while popping.
    assign pop  = (count != '0) && (rc != '0);
    assign push = wvalid && (count != FULL_CNT);

    // An entry is live when its distance from the head, walking forward with wrap, is below count.
    always_comb begin
        hit     = '0;
        hit_cnt = '0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (OFF_W'(i) >= OFF_W'(rd_ptr))
                off = OFF_W'(i) - OFF_W'(rd_ptr);
            else
                off = OFF_W'(i) + OFF_W'(DEPTH) - OFF_W'(rd_ptr);
            hit[i]  = (off < OFF_W'(count)) && (((mem[i] ^ sdata) & smask) == '0);
            hit_cnt = hit_cnt + CNT_W'(hit[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rc         <= '0;
            count      <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
            wcredit    <= 1'b0;
            smatch     <= 1'b0;
            smatch_cnt <= '0;
            err_ovf    <= 1'b0;
            err_crd    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (wvalid && !push) err_ovf <= 1'b1;

            if (pop) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= ptr_inc(rd_ptr);
            end
            rvalid  <= pop;
            wcredit <= pop;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case ({rcredit, pop})
                2'b10: begin
                    if (rc == RC_TOP) err_crd <= 1'b1;
                    else              rc      <= rc + 1'b1;
                end
                2'b01:   rc <= rc - 1'b1;
                default: rc <= rc;
            endcase

            smatch     <= svalid && (|hit);
            smatch_cnt <= svalid ? hit_cnt : '0;
        end
    end

endmodule

// File: tb/tb_ah_snoop_credit_fifo.sv
// tb/tb_ah_snoop_credit_fifo.sv - randomized and directed bench for ah_snoop_credit_fifo against a queue model
module tb_ah_snoop_credit_fifo;

    localparam int W     = 164;
    localparam int DA    = 48;
    localparam int DB    = 5;
    localparam int RMAX  = 4;
    localparam int CWA   = $clog2(DA + 1);
    localparam int CWB   = $clog2(DB + 1);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [W-1:0] wdata = '0, sdata = '0, smask = '0;
    logic wvalid = 1'b0, rcredit = 1'b0, svalid = 1'b0;

    logic [W-1:0]   a_rdata, b_rdata;
    logic           a_wcredit, a_rvalid, a_smatch, a_err_ovf, a_err_crd;
    logic           b_wcredit, b_rvalid, b_smatch, b_err_ovf, b_err_crd;
    logic [CWA-1:0] a_smatch_cnt, a_count;
    logic [CWB-1:0] b_smatch_cnt, b_count;

    always #5 clk = ~clk;

    ah_snoop_credit_fifo dut_a (
        .clk(clk), .rstn(rstn), .wdata(wdata), .wvalid(wvalid), .wcredit(a_wcredit),
        .rdata(a_rdata), .rvalid(a_rvalid), .rcredit(rcredit), .sdata(sdata), .smask(smask),
        .svalid(svalid), .smatch(a_smatch), .smatch_cnt(a_smatch_cnt), .count(a_count),
        .err_ovf(a_err_ovf), .err_crd(a_err_crd)
    );

    ah_snoop_credit_fifo #(.DEPTH(DB)) dut_b (
        .clk(clk), .rstn(rstn), .wdata(wdata), .wvalid(wvalid), .wcredit(b_wcredit),
        .rdata(b_rdata), .rvalid(b_rvalid), .rcredit(rcredit), .sdata(sdata), .smask(smask),
        .svalid(svalid), .smatch(b_smatch), .smatch_cnt(b_smatch_cnt), .count(b_count),
        .err_ovf(b_err_ovf), .err_crd(b_err_crd)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues, a credit count and sticky flags per instance.
    logic [W-1:0] qa[$], qb[$];
    int           mca, mcb, sna, snb;
    bit           popa, popb, ovfa, ovfb, crda, crdb;
    logic [W-1:0] rda, rdb;

    int           rv_cnt_a;
    logic [W-1:0] last_a;
    logic [W-1:0] got_b[$];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic int snoop_cnt(input logic [W-1:0] qq[$]);
        int n = 0;
        if (!svalid) return 0;
        foreach (qq[i]) if (((qq[i] ^ sdata) & smask) == '0) n++;
        return n;
    endfunction

    task automatic compare();
        chk("a_rvalid",  W'(a_rvalid),     W'(popa));
        chk("a_wcredit", W'(a_wcredit),    W'(popa));
        chk("a_rdata",   a_rdata,          rda);
        chk("a_count",   W'(a_count),      W'(qa.size()));
        chk("a_smatch",  W'(a_smatch),     W'(sna > 0));
        chk("a_scnt",    W'(a_smatch_cnt), W'(sna));
        chk("a_ovf",     W'(a_err_ovf),    W'(ovfa));
        chk("a_crd",     W'(a_err_crd),    W'(crda));
        chk("b_rvalid",  W'(b_rvalid),     W'(popb));
        chk("b_wcredit", W'(b_wcredit),    W'(popb));
        chk("b_rdata",   b_rdata,          rdb);
        chk("b_count",   W'(b_count),      W'(qb.size()));
        chk("b_smatch",  W'(b_smatch),     W'(snb > 0));
        chk("b_scnt",    W'(b_smatch_cnt), W'(snb));
        chk("b_ovf",     W'(b_err_ovf),    W'(ovfb));
        chk("b_crd",     W'(b_err_crd),    W'(crdb));
    endtask

    task automatic cyc();
        bit pusha, pushb;
        sna   = snoop_cnt(qa);
        snb   = snoop_cnt(qb);
        popa  = (qa.size() > 0) && (mca > 0);
        popb  = (qb.size() > 0) && (mcb > 0);
        pusha = wvalid && (qa.size() < DA);
        pushb = wvalid && (qb.size() < DB);
        if (wvalid && !pusha) ovfa = 1;
        if (wvalid && !pushb) ovfb = 1;
        if (popa) rda = qa.pop_front();
        if (popb) rdb = qb.pop_front();
        if (pusha) qa.push_back(wdata);
        if (pushb) qb.push_back(wdata);
        if (rcredit && !popa) begin if (mca == RMAX) crda = 1; else mca++; end
        if (!rcredit && popa) mca--;
        if (rcredit && !popb) begin if (mcb == RMAX) crdb = 1; else mcb++; end
        if (!rcredit && popb) mcb--;
        @(posedge clk);
        #1;
        compare();
        if (a_rvalid) begin rv_cnt_a++; last_a = a_rdata; end
        if (b_rvalid) got_b.push_back(b_rdata);
    endtask

    task automatic idle(input int n);
        wvalid = 0; rcredit = 0; svalid = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic push(input logic [W-1:0] d);
        wvalid = 1; wdata = d;
        cyc();
        wvalid = 0;
    endtask

    // Called just after an active edge: reset lands between edges so its effect is asynchronous.
    task automatic hard_reset();
        wvalid = 0; rcredit = 0; svalid = 0;
        rstn = 0;
        #2;
        qa.delete(); qb.delete();
        mca = 0; mcb = 0; sna = 0; snb = 0;
        popa = 0; popb = 0; ovfa = 0; ovfb = 0; crda = 0; crdb = 0;
        rda = '0; rdb = '0;
        compare();
        @(posedge clk);
        #1;
        rstn = 1;
        rv_cnt_a = 0;
        got_b.delete();
    endtask

    initial begin
        logic [W-1:0] d, head;
        int           keys[4];
        keys = '{3, 5, 3, 7};

        hard_reset();

        // Credits gate delivery: three entries queued, two credits release exactly two.
        for (int i = 1; i <= 3; i++) push(W'(i));
        idle(2);
        chk("tp1_count3", W'(a_count), W'(3));
        chk("tp1_no_rv", W'(rv_cnt_a), W'(0));
        rcredit = 1; cyc(); cyc(); rcredit = 0;
        idle(4);
        chk("tp1_rv2", W'(rv_cnt_a), W'(2));
        chk("tp1_last", last_a, W'(2));
        chk("tp1_count1", W'(a_count), W'(1));

        // Depth-5 pointer wrap with credits streaming.
        hard_reset();
        rcredit = 1;
        for (int i = 1; i <= 13; i++) push(W'(i));
        rcredit = 0;
        idle(4);
        chk("tp2_n", W'(got_b.size()), W'(13));
        for (int i = 0; i < got_b.size() && i < 13; i++) chk("tp2_order", got_b[i], W'(i + 1));
        chk("tp2_ovf", W'(b_err_ovf), W'(0));
        chk("tp2_crd", W'(b_err_crd), W'(0));

        // Fill 48, overflow once, then drain: the 49th value must never appear.
        hard_reset();
        for (int i = 1; i <= DA + 1; i++) push(W'(i));
        chk("tp3_full", W'(a_count), W'(DA));
        chk("tp3_ovf", W'(a_err_ovf), W'(1));
        rcredit = 1;
        for (int i = 0; i < DA; i++) cyc();
        rcredit = 0;
        idle(4);
        chk("tp3_rv", W'(rv_cnt_a), W'(DA));
        chk("tp3_last", last_a, W'(DA));
        chk("tp3_empty", W'(a_count), W'(0));

        // Masked snoop on keyed entries, including same-cycle push and pop snapshots.
        hard_reset();
        head = '0;
        for (int i = 0; i < 4; i++) begin
            d = rnd(); d[2:0] = 3'(keys[i]);
            if (i == 0) head = d;
            push(d);
        end
        svalid = 1; smask = W'(7);
        sdata = W'(3); cyc(); chk("tp4_k3_cnt", W'(a_smatch_cnt), W'(2)); chk("tp4_k3_m", W'(a_smatch), W'(1));
        sdata = W'(4); cyc(); chk("tp4_k4_cnt", W'(a_smatch_cnt), W'(0)); chk("tp4_k4_m", W'(a_smatch), W'(0));
        smask = '0;    cyc(); chk("tp4_all", W'(a_smatch_cnt), W'(4));
        d = rnd(); d[2:0] = 3'd6;
        smask = W'(7); sdata = W'(6); wvalid = 1; wdata = d;
        cyc(); wvalid = 0;
        chk("tp4_pushsnap", W'(a_smatch), W'(0));
        svalid = 0; rcredit = 1; cyc(); rcredit = 0;
        svalid = 1; sdata = head; smask = '1;
        cyc(); svalid = 0;
        chk("tp4_popsnap_m", W'(a_smatch), W'(1));
        chk("tp4_popsnap_c", W'(a_smatch_cnt), W'(1));
        chk("tp4_popsnap_rv", W'(a_rvalid), W'(1));
        idle(2);

        // Read-credit saturation, then only the held credits drain data.
        hard_reset();
        rcredit = 1;
        for (int i = 0; i < RMAX + 1; i++) cyc();
        rcredit = 0;
        chk("tp5_crd", W'(a_err_crd), W'(1));
        for (int i = 0; i < 5; i++) push(rnd());
        idle(8);
        chk("tp5_rv4", W'(rv_cnt_a), W'(RMAX));
        rcredit = 1;
        for (int i = 0; i < 3; i++) push(rnd());
        hard_reset();
        chk("tp5_rst_count", W'(a_count), W'(0));

        // Randomized traffic with one reset mid-run.
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) hard_reset();
            wvalid  = ($urandom_range(99) < 55);
            rcredit = ($urandom_range(99) < 45);
            svalid  = ($urandom_range(99) < 50);
            wdata   = rnd();
            sdata   = W'($urandom_range(7));
            case ($urandom_range(3))
                0:       smask = '0;
                1:       smask = W'(7);
                2:       smask = W'(3);
                default: smask = '1;
            endcase
            cyc();
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
